// File: rtl/sram_sched_pkg.sv
// Shared types and default sizing for the SRAM request scheduler.
package sram_sched_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 36;
    localparam int DEPTH_DEF  = 4;
    localparam int RD_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sram_req_sched_if.sv
// Request-side valid/ready handshake into the SRAM scheduler.
interface sram_req_sched_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 36
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    modport master (output req_valid, req_wr, req_addr, req_wdata, input req_ready);
    modport slave  (input req_valid, req_wr, req_addr, req_wdata, output req_ready);
endinterface

// File: rtl/sram_req_fifo.sv
// Request FIFO: registered head, no fall-through, extra pointer bit for full/empty.
module sram_req_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 4
) (
    input  logic             memclk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty is decided by the pointers alone.
    always_ff @(posedge memclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sram_req_sched.sv
// Launches queued requests as 2-cycle SRAM commands aligned to phase==0,
// and returns read data RD_LAT cycles after each read's ISSUE cycle.
module sram_req_sched
    import sram_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              memclk,
    input  logic              reset,
    input  logic              phase,
    sram_req_sched_if.slave   req,
    output logic              sram_cmd_valid,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    sched_state_e      state;
    sched_state_e      state_nxt;
    logic              launch;
    logic              init_q;
    logic              full;
    logic              empty;
    logic              push;
    req_t              push_req;
    req_t              head;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              issue_rd;
    logic [RD_LAT:1]   vld_pipe;

    // init_q holds req_ready low until the first edge out of reset.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) init_q <= 1'b0;
        else       init_q <= 1'b1;
    end

    assign req.req_ready = init_q && !full;
    assign push          = req.req_valid && req.req_ready;
    assign push_req      = {req.req_wr, req.req_addr, req.req_wdata};

    sram_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .memclk (memclk),
        .reset  (reset),
        .push   (push),
        .wdata  (push_req),
        .pop    (launch),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !phase) begin
                    launch    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = HOLD;
            HOLD: begin
                if (!empty && !phase) begin
                    launch    = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command fields load at launch; only we drops on return to IDLE.
    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (launch) begin
            we_q    <= head.wr;
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
        end else if (state == HOLD) begin
            we_q    <= 1'b0;
        end
    end

    assign sram_cmd_valid = (state != IDLE);
    assign sram_we        = we_q;
    assign sram_addr      = addr_q;
    assign sram_wdata     = wdata_q;

    // Read tag enters during ISSUE and reaches rd_valid RD_LAT edges later.
    assign issue_rd = (state == ISSUE) && !we_q;

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:1], issue_rd};
            if (vld_pipe[RD_LAT-1]) rd_data <= sram_rdata;
        end
    end

    assign rd_valid = vld_pipe[RD_LAT];

endmodule

// File: tb/tb_sram_req_sched.sv
// Directed bench for sram_req_sched with a small delayed-address SRAM read model.
module tb_sram_req_sched;
    localparam int AW = 20;
    localparam int DW = 36;

    logic          memclk = 1'b0;
    logic          reset  = 1'b1;
    logic          phase  = 1'b1;
    logic          sram_cmd_valid, sram_we, rd_valid;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata, rd_data;

    sram_req_sched_if #(.ADDR_W(AW), .DATA_W(DW)) rif();

    sram_req_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RD_LAT(4)) dut (
        .memclk         (memclk),
        .reset          (reset),
        .phase          (phase),
        .req            (rif),
        .sram_cmd_valid (sram_cmd_valid),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data)
    );

    always #5 memclk = ~memclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic phase_run = 1'b0;
    logic last_ph   = 1'b1;

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic ph; } cmd_t;
    typedef struct { int cyc; logic [DW-1:0] data; } rd_t;
    cmd_t cmds[$];
    rd_t  rds[$];
    int   run = 0, len_err = 0, stab_err = 0;

    // SRAM model: data for the address seen at the command's first cycle,
    // presented three cycles later so it is captured RD_LAT after ISSUE.
    logic [AW-1:0] a1 = '0, a2 = '0, a3 = '0;
    logic          force_en  = 1'b0;
    logic [DW-1:0] force_val = '0;
    assign sram_rdata = force_en ? force_val : {16'hD00D, a3};

    always @(posedge memclk) begin
        a1 <= sram_addr;
        a2 <= a1;
        a3 <= a2;
    end

    always @(posedge memclk) begin
        last_ph = phase;
        cyc     = cyc + 1;
    end

    always @(negedge memclk) begin
        if (reset) begin
            run = 0;
        end else if (sram_cmd_valid) begin
            if (run % 2 == 0)
                cmds.push_back('{cyc, sram_we, sram_addr, sram_wdata, last_ph});
            else if (cmds.size() > 0 && (cmds[$].we !== sram_we || cmds[$].addr !== sram_addr ||
                     cmds[$].wdata !== sram_wdata))
                stab_err++;
            run++;
        end else begin
            if (run % 2 != 0) len_err++;
            run = 0;
        end
        if (rd_valid && !reset) rds.push_back('{cyc, rd_data});
    end

    task automatic tick();
        @(posedge memclk);
        #1;
        if (phase_run) phase = ~phase;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rif.req_valid = 1'b0;
        phase_run = 1'b0;
        phase = 1'b1;
        force_en = 1'b0;
        repeat (2) tick();
        cmds.delete();
        rds.delete();
        len_err = 0;
        stab_err = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        rif.req_valid = 1'b1;
        rif.req_wr    = wr;
        rif.req_addr  = a;
        rif.req_wdata = d;
        while (!rif.req_ready && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (rif.req_ready !== 1'b1) begin bad++; $display("FAIL push_timeout addr=%h ready=%b want 1", a, rif.req_ready); end
        tick();
        rif.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rif.req_valid = 1'b0;
        rif.req_wr = 1'b0;
        rif.req_addr = '0;
        rif.req_wdata = '0;
        repeat (2) tick();
        total++;
        if (rif.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", rif.req_ready); end
        total++;
        if ({sram_cmd_valid, sram_we, sram_addr, sram_wdata} !== '0) begin
            bad++; $display("FAIL rst_cmd got %b/%b/%h/%h want zeros", sram_cmd_valid, sram_we, sram_addr, sram_wdata);
        end
        total++;
        if ({rd_valid, rd_data} !== '0) begin bad++; $display("FAIL rst_rd got %b/%h want zeros", rd_valid, rd_data); end
        reset = 1'b0;
        tick();
        total++;
        if (rif.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", rif.req_ready); end
    endtask

    task automatic test_single_write();
        int pc;
        do_reset();
        phase_run = 1'b1;
        push(1'b1, 20'h00010, 36'h123456789);
        pc = cyc;
        repeat (12) tick();
        total++;
        if (cmds.size() != 1) begin bad++; $display("FAIL wr_cmd_count got %0d want 1", cmds.size()); end
        if (cmds.size() == 1) begin
            total++;
            if (cmds[0].we !== 1'b1 || cmds[0].addr !== 20'h00010 || cmds[0].wdata !== 36'h123456789) begin
                bad++; $display("FAIL wr_fields got %b/%h/%h want 1/00010/123456789", cmds[0].we, cmds[0].addr, cmds[0].wdata);
            end
            total++;
            if (cmds[0].ph !== 1'b0 || cmds[0].cyc <= pc) begin
                bad++; $display("FAIL wr_launch_phase got ph=%b cyc=%0d want ph=0 cyc>%0d", cmds[0].ph, cmds[0].cyc, pc);
            end
        end
        total++;
        if (len_err != 0 || stab_err != 0) begin bad++; $display("FAIL wr_len_stable got len=%0d stab=%0d want 0/0", len_err, stab_err); end
        total++;
        if (rds.size() != 0) begin bad++; $display("FAIL wr_no_rd got %0d want 0", rds.size()); end
        total++;
        if (sram_cmd_valid !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 20'h00010) begin
            bad++; $display("FAIL wr_idle got %b/%b/%h want 0/0/00010", sram_cmd_valid, sram_we, sram_addr);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        phase_run = 1'b1;
        force_en = 1'b1;
        force_val = 36'hABCDE0123;
        push(1'b0, 20'h00020, 36'h0);
        repeat (14) tick();
        total++;
        if (cmds.size() != 1 || rds.size() != 1) begin
            bad++; $display("FAIL rd_counts got cmds=%0d rds=%0d want 1/1", cmds.size(), rds.size());
        end
        if (cmds.size() == 1 && rds.size() == 1) begin
            total++;
            if (rds[0].cyc != cmds[0].cyc + 4) begin bad++; $display("FAIL rd_latency got %0d want %0d", rds[0].cyc, cmds[0].cyc + 4); end
            total++;
            if (rds[0].data !== 36'hABCDE0123) begin bad++; $display("FAIL rd_data got %h want abcde0123", rds[0].data); end
            total++;
            if (cmds[0].we !== 1'b0 || cmds[0].addr !== 20'h00020) begin
                bad++; $display("FAIL rd_cmd got %b/%h want 0/00020", cmds[0].we, cmds[0].addr);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b1, AW'(32'h100 + i), DW'(32'h5000 + i));
        total++;
        if (rif.req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %b want 0", rif.req_ready); end
        rif.req_valid = 1'b1;
        rif.req_wr = 1'b1;
        rif.req_addr = 20'h00104;
        rif.req_wdata = 36'h5004;
        repeat (3) tick();
        total++;
        if (rif.req_ready !== 1'b0 || cmds.size() != 0) begin
            bad++; $display("FAIL bp_stalled got ready=%b cmds=%0d want 0/0", rif.req_ready, cmds.size());
        end
        phase_run = 1'b1;
        while (!rif.req_ready && n < 10) begin tick(); n++; end
        total++;
        if (rif.req_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready got %b want 1", rif.req_ready); end
        tick();
        rif.req_valid = 1'b0;
        repeat (14) tick();
        total++;
        if (cmds.size() != 5) begin bad++; $display("FAIL bp_cmd_count got %0d want 5", cmds.size()); end
        for (int i = 0; i < 5 && i < cmds.size(); i++) begin
            total++;
            if (cmds[i].addr !== AW'(32'h100 + i) || cmds[i].wdata !== DW'(32'h5000 + i)) begin
                bad++; $display("FAIL bp_order[%0d] got %h/%h want %h/%h", i, cmds[i].addr, cmds[i].wdata, 32'h100 + i, 32'h5000 + i);
            end
            if (i > 0) begin
                total++;
                if (cmds[i].cyc != cmds[i-1].cyc + 2) begin
                    bad++; $display("FAIL bp_gap[%0d] got %0d want %0d", i, cmds[i].cyc, cmds[i-1].cyc + 2);
                end
            end
        end
        total++;
        if (len_err != 0 || stab_err != 0) begin bad++; $display("FAIL bp_len_stable got len=%0d stab=%0d want 0/0", len_err, stab_err); end
    endtask

    task automatic test_stream();
        logic [AW-1:0] ea;
        do_reset();
        phase_run = 1'b1;
        for (int i = 0; i < 8; i++) push(i % 2 == 1, AW'(32'h200 + i), DW'(32'h7000 + i));
        repeat (20) tick();
        total++;
        if (cmds.size() != 8) begin bad++; $display("FAIL st_cmd_count got %0d want 8", cmds.size()); end
        for (int i = 0; i < 8 && i < cmds.size(); i++) begin
            total++;
            if (cmds[i].addr !== AW'(32'h200 + i) || cmds[i].we !== (i % 2 == 1)) begin
                bad++; $display("FAIL st_cmd[%0d] got %h/%b want %h/%b", i, cmds[i].addr, cmds[i].we, 32'h200 + i, i % 2);
            end
            if (i > 0) begin
                total++;
                if (cmds[i].cyc != cmds[i-1].cyc + 2) begin
                    bad++; $display("FAIL st_gap[%0d] got %0d want %0d", i, cmds[i].cyc, cmds[i-1].cyc + 2);
                end
            end
        end
        total++;
        if (rds.size() != 4) begin bad++; $display("FAIL st_rd_count got %0d want 4", rds.size()); end
        for (int j = 0; j < 4 && j < rds.size() && 2 * j < cmds.size(); j++) begin
            ea = AW'(32'h200 + 2 * j);
            total++;
            if (rds[j].data !== {16'hD00D, ea} || rds[j].cyc != cmds[2*j].cyc + 4) begin
                bad++; $display("FAIL st_rd[%0d] got %h@%0d want %h@%0d", j, rds[j].data, rds[j].cyc, {16'hD00D, ea}, cmds[2*j].cyc + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push(1'b0, 20'h00300, 36'h0);
        push(1'b1, 20'h00301, 36'h1);
        push(1'b1, 20'h00302, 36'h2);
        phase_run = 1'b1;
        while (!sram_cmd_valid && n < 20) begin tick(); n++; end
        tick();
        total++;
        if (sram_cmd_valid !== 1'b1 || sram_addr !== 20'h00300) begin
            bad++; $display("FAIL rm_hold got %b/%h want 1/00300", sram_cmd_valid, sram_addr);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({sram_cmd_valid, sram_we, sram_addr, sram_wdata, rd_valid, rd_data, rif.req_ready} !== '0) begin
            bad++; $display("FAIL rm_clear got %b/%b/%h/%h/%b/%h/%b want zeros", sram_cmd_valid, sram_we, sram_addr,
                            sram_wdata, rd_valid, rd_data, rif.req_ready);
        end
        repeat (2) tick();
        cmds.delete();
        rds.delete();
        reset = 1'b0;
        tick();
        total++;
        if (rif.req_ready !== 1'b1) begin bad++; $display("FAIL rm_release_ready got %b want 1", rif.req_ready); end
        repeat (12) tick();
        total++;
        if (cmds.size() != 0 || rds.size() != 0) begin
            bad++; $display("FAIL rm_discard got cmds=%0d rds=%0d want 0/0", cmds.size(), rds.size());
        end
    endtask

    task automatic test_push_pop();
        logic [2:0] occ;
        do_reset();
        push(1'b1, 20'h00400, 36'hAA);
        rif.req_valid = 1'b1;
        rif.req_wr = 1'b1;
        rif.req_addr = 20'h00401;
        rif.req_wdata = 36'hBB;
        phase = 1'b0;
        tick();
        rif.req_valid = 1'b0;
        occ = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;
        total++;
        if (occ !== 3'd1 || rif.req_ready !== 1'b1) begin bad++; $display("FAIL pp_occupancy got %0d/%b want 1/1", occ, rif.req_ready); end
        total++;
        if (sram_cmd_valid !== 1'b1 || sram_addr !== 20'h00400) begin
            bad++; $display("FAIL pp_launch got %b/%h want 1/00400", sram_cmd_valid, sram_addr);
        end
        phase = 1'b1;
        phase_run = 1'b1;
        repeat (8) tick();
        total++;
        if (cmds.size() != 2) begin bad++; $display("FAIL pp_cmd_count got %0d want 2", cmds.size()); end
        if (cmds.size() == 2) begin
            total++;
            if (cmds[1].addr !== 20'h00401 || cmds[1].wdata !== 36'hBB || cmds[1].cyc != cmds[0].cyc + 2) begin
                bad++; $display("FAIL pp_next got %h/%h@%0d want 00401/bb@%0d", cmds[1].addr, cmds[1].wdata, cmds[1].cyc, cmds[0].cyc + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
